// File: rtl/stream_sum_arbiter.sv
// Round-robin owner of a single wrapping stream-sum accumulator shared by N requesters.
// A granted requester owns the adder for its whole stream; the sum is returned tagged with its id.

module stream_sum_lane #(
   parameter int WIDTH = 8,
   parameter int IDW   = 2,
   parameter int LANE  = 0
) (
   input  logic [IDW-1:0]   gnt,
   input  logic             busy_st,
   input  logic             valid,
   input  logic             last,
   input  logic [WIDTH-1:0] data,
   output logic             ready,
   output logic             valid_m,
   output logic             last_m,
   output logic [WIDTH-1:0] data_m
);
   localparam logic [IDW-1:0] LANE_ID = IDW'(LANE);

   logic sel;

   // Losers see ready low and contribute zeros, so the OR-merge is a clean mux.
   assign sel     = (gnt == LANE_ID);
   assign ready   = busy_st & sel;
   assign valid_m = sel & valid;
   assign last_m  = sel & last;
   assign data_m  = sel ? data : '0;
endmodule

module stream_sum_arbiter #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int IDW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [N-1:0]       req_valid,
   input  logic [N-1:0]       req_last,
   input  logic [N*WIDTH-1:0] req_data,
   output logic [N-1:0]       req_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
   output logic [IDW-1:0]     out_id,
   output logic               busy
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             last;
      logic [WIDTH-1:0] data;
   } beat_t;

   state_t state, state_nxt;

   logic [IDW-1:0]   ptr, gnt;
   logic [WIDTH-1:0] acc;
   logic             busy_st;

   logic [N-1:0]              lane_valid, lane_last;
   logic [N-1:0][WIDTH-1:0]   lane_data;
   beat_t                     sel_beat;

   logic             arb_hit;
   logic [IDW-1:0]   arb_idx;
   logic             beat_xfer, last_xfer, res_xfer;
   logic [WIDTH-1:0] sum_nxt;
   logic [IDW-1:0]   ptr_nxt;

   // ---------------- per-requester lanes ----------------
   for (genvar i = 0; i < N; i++) begin : g_lane
      stream_sum_lane #(
         .WIDTH (WIDTH),
         .IDW   (IDW),
         .LANE  (i)
      ) u_lane (
         .gnt     (gnt),
         .busy_st (busy_st),
         .valid   (req_valid[i]),
         .last    (req_last[i]),
         .data    (req_data[i*WIDTH +: WIDTH]),
         .ready   (req_ready[i]),
         .valid_m (lane_valid[i]),
         .last_m  (lane_last[i]),
         .data_m  (lane_data[i])
      );
   end

   always_comb begin
      sel_beat = '0;
      for (int i = 0; i < N; i++) begin
         sel_beat.valid = sel_beat.valid | lane_valid[i];
         sel_beat.last  = sel_beat.last  | lane_last[i];
         sel_beat.data  = sel_beat.data  | lane_data[i];
      end
   end

   // ---------------- round-robin search from ptr ----------------
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (!arb_hit && req_valid[j]) begin
            arb_hit = 1'b1;
            arb_idx = IDW'(j);
         end
      end
   end

   assign beat_xfer = busy_st & sel_beat.valid;
   assign last_xfer = beat_xfer & sel_beat.last;
   assign res_xfer  = (state == ST_DONE) & out_ready;
   assign sum_nxt   = acc + sel_beat.data;
   assign ptr_nxt   = (gnt == IDW'(N-1)) ? '0 : gnt + IDW'(1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (arb_hit)   state_nxt = ST_BUSY;
         ST_BUSY: if (last_xfer) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // Outputs come only from registered state, never from out_ready/req_valid.
   always_comb begin
      busy_st   = (state == ST_BUSY);
      out_valid = (state == ST_DONE);
      busy      = (state == ST_BUSY) | (state == ST_DONE);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         acc     <= '0;
         ptr     <= '0;
         gnt     <= '0;
         out_sum <= '0;
         out_id  <= '0;
      end else begin
         if (state == ST_IDLE && arb_hit) begin
            gnt <= arb_idx;
            acc <= '0;
         end
         if (beat_xfer) acc <= sum_nxt;
         if (last_xfer) begin
            out_sum <= sum_nxt;
            out_id  <= gnt;
         end
         if (res_xfer) ptr <= ptr_nxt;
      end
   end
endmodule

// File: tb/tb_stream_sum_arbiter.sv
// Directed scoreboard bench for stream_sum_arbiter: expected {id,sum} queued at stimulus, popped at result.

module tb_stream_sum_arbiter;
   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int IDW   = 2;

   logic               clk = 1'b0;
   logic               nrst;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_last;
   logic [N*WIDTH-1:0] req_data;
   logic [N-1:0]       req_ready;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_sum;
   logic [IDW-1:0]     out_id;
   logic               busy;

   int n_cmp = 0;
   int n_mis = 0;
   logic [IDW+WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   stream_sum_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
   endtask

   // Called just after a rising edge; returns just after the edge that moved the beat.
   task automatic beat(input int i, input logic [WIDTH-1:0] d, input logic l);
      req_valid[i] = 1'b1;
      req_last[i]  = l;
      req_data[i*WIDTH +: WIDTH] = d;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready[i]) break;
      end
      chk("beat_ready", {31'd0, req_ready[i]}, 32'd1);
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
   endtask

   // Waits for out_valid (out_ready must already be 1), checks against the queue head.
   task automatic get_result(input string tag, output int waited);
      logic [IDW+WIDTH-1:0] e;
      waited = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) break;
         waited++;
      end
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_qempty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_sum"}, {24'd0, out_sum}, {24'd0, e[WIDTH-1:0]});
         chk({tag, "_id"},  {30'd0, out_id},  {30'd0, e[IDW+WIDTH-1:WIDTH]});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b1;

      // Reset values
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_out_sum",   {24'd0, out_sum},   32'd0);
      chk("rst_out_id",    {30'd0, out_id},    32'd0);
      @(posedge clk); #1;

      // Single stream with wrap: 1+2+3+FF = 0x105 -> 0x05
      exp_q.push_back({2'd0, 8'h05});
      beat(0, 8'h01, 1'b0);
      beat(0, 8'h02, 1'b0);
      beat(0, 8'h03, 1'b0);
      beat(0, 8'hFF, 1'b1);
      get_result("single", w);
      chk("single_latency", w, 0);

      // Round-robin with all four holding single-beat streams
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         req_last[i]  = 1'b1;
         req_data[i*WIDTH +: WIDTH] = 8'(8'h10 * (i + 1));
      end
      for (int k = 0; k < N; k++) begin
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|req_ready) break;
         end
         chk("rr_grant", {28'd0, req_ready}, 32'd1 << k);
         exp_q.push_back({2'(k), 8'(8'h10 * (k + 1))});
         @(posedge clk); #1;
         req_valid[k] = 1'b0;
         req_last[k]  = 1'b0;
         get_result("rr", w);
      end
      exp_q.push_back({2'd0, 8'h55});
      beat(0, 8'h55, 1'b1);
      get_result("rr_wrap", w);

      // Backpressure: ptr now 1; requester 2 waits behind requester 1
      out_ready = 1'b0;
      req_valid[2] = 1'b1;
      req_last[2]  = 1'b1;
      req_data[2*WIDTH +: WIDTH] = 8'h0A;
      exp_q.push_back({2'd1, 8'h05});
      beat(1, 8'h02, 1'b0);
      beat(1, 8'h03, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sum",   {24'd0, out_sum},   32'h05);
         chk("bp_id",    {30'd0, out_id},    32'd1);
         chk("bp_ready", {28'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      get_result("bp", w);
      @(negedge clk);
      chk("bp_idle_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("bp_next_grant", {28'd0, req_ready}, 32'b0100);
      exp_q.push_back({2'd2, 8'h0A});
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      req_last[2]  = 1'b0;
      get_result("bp_next", w);

      // Bubbles: 0x80, -, -, 0x80, -, 0x01 -> 0x01
      exp_q.push_back({2'd2, 8'h01});
      beat(2, 8'h80, 1'b0);
      @(negedge clk);
      chk("bub_acc_a", {24'd0, dut.acc}, 32'h80);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bub_acc_b", {24'd0, dut.acc}, 32'h80);
      @(posedge clk); #1;
      beat(2, 8'h80, 1'b0);
      @(negedge clk);
      chk("bub_acc_c", {24'd0, dut.acc}, 32'h00);
      @(posedge clk); #1;
      beat(2, 8'h01, 1'b1);
      get_result("bub", w);

      // Stall of losers: move ptr to 1, then requester 1 wins over waiting 3
      exp_q.push_back({2'd0, 8'h07});
      beat(0, 8'h07, 1'b1);
      get_result("stall_pre", w);
      req_valid[3] = 1'b1;
      req_last[3]  = 1'b1;
      req_data[3*WIDTH +: WIDTH] = 8'h33;
      exp_q.push_back({2'd1, 8'h33});
      beat(1, 8'h11, 1'b0);
      @(negedge clk);
      chk("stall_ready", {28'd0, req_ready}, 32'b0010);
      @(posedge clk); #1;
      beat(1, 8'h22, 1'b1);
      get_result("stall_r1", w);
      @(negedge clk);
      chk("stall_idle", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("stall_gnt3", {28'd0, req_ready}, 32'b1000);
      exp_q.push_back({2'd3, 8'h33});
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      req_last[3]  = 1'b0;
      get_result("stall_r3", w);

      // Reset mid-stream aborts with no result
      beat(0, 8'h01, 1'b0);
      beat(0, 8'h02, 1'b0);
      nrst = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      @(negedge clk);
      chk("mrst_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_busy",  {31'd0, busy},      32'd0);
      chk("mrst_ready", {28'd0, req_ready}, 32'd0);
      chk("mrst_sum",   {24'd0, out_sum},   32'd0);
      chk("mrst_id",    {30'd0, out_id},    32'd0);
      chk("mrst_acc",   {24'd0, dut.acc},   32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mrst_no_out", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      exp_q.push_back({2'd0, 8'h07});
      beat(0, 8'h07, 1'b1);
      get_result("mrst_fresh", w);

      chk("q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/stream_sum_arbiter.md
# stream_sum_arbiter

Round-robin scheduler that shares one wrapping stream-sum accumulator between `N` independent requester streams. Each requester presents a stream of `WIDTH`-bit beats terminated by a `last` flag. The block grants the accumulator to one requester for its whole stream, reduces the stream to a single sum, and returns the sum tagged with the requester id over a valid/ready output. It sits between multiple stream producers and the consumer of their reductions, so the design instantiates a single sum datapath instead of one per producer.

## Interface
- `WIDTH`, 8: beat and sum width in bits; the sum wraps modulo 2^WIDTH.
- `N`, 4: number of requesters; N ≥ 2.
- `IDW`, `$clog2(N)`: width of the requester id.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `nrst`  in  1  synchronous, active-low reset.
- `req_valid`  in  N  per-requester beat valid.
- `req_last`  in  N  per-requester final-beat flag; qualified by `req_valid`.
- `req_data`  in  N*WIDTH  per-requester beat; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  N  per-requester beat accept; one-hot or zero.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  WIDTH  wrapped sum of the granted stream.
- `out_id`  out  IDW  index of the requester that produced `out_sum`.
- `busy`  out  1  high in BUSY and DONE.

## Operation
- A beat transfers when `req_valid[i] & req_ready[i]`. The result transfers when `out_valid & out_ready`.
- State machine:
  - IDLE: `req_ready` = 0. If any `req_valid` is high, grant the first set bit searching upward from `ptr`, wrapping modulo N. On that edge: latch `gnt`, set `acc` = 0, go to BUSY. Otherwise stay in IDLE.
  - BUSY: `req_ready` = one-hot(`gnt`) and all other bits are 0. On each transfer, `acc` ← `acc + data` modulo 2^WIDTH. If the transfer has `req_last[gnt]` set, the edge also loads `out_sum` ← `acc + data`, `out_id` ← `gnt`, and goes to DONE. A cycle without a transfer holds `acc`; bubbles are legal.
  - DONE: `out_valid` = 1 and `req_ready` = 0. On result transfer: `ptr` ← (`gnt` + 1) mod N, go to IDLE.
- Streams are at least one beat long. A beat with `last` set and no prior beats yields `out_sum` = that beat.
- Non-granted requesters are stalled. Their inputs are ignored and must be held by the producer; data is never dropped.
- Arithmetic is an unsigned WIDTH-bit add. Carry is discarded and no overflow flag is produced.
- `out_sum` and `out_id` are stable from DONE entry until the result transfer.

## Timing
- Reset values (at any edge with `nrst` = 0): state IDLE, `acc` 0, `ptr` 0, `gnt` 0, `out_valid` 0, `out_sum` 0, `out_id` 0, `req_ready` 0, `busy` 0.
- Reset mid-stream or in DONE aborts the stream. The pending result is discarded. No output is produced for the aborted stream.
- Grant latency: a request seen in IDLE gives `req_ready` high on the next cycle.
- Throughput in BUSY: one beat per cycle.
- Result latency: `out_valid` rises the cycle after the `last` transfer.
- Per-stream overhead: 1 IDLE cycle plus at least 1 DONE cycle. Back-to-back streams from different requesters have a minimum 2-cycle gap between the `last` transfer and the next first-beat transfer.
- A request arriving while BUSY or DONE waits. The request must be held until IDLE arbitrates.
- Fairness: the just-served requester has lowest priority in the next arbitration. With all N requesting continuously, grants go 0,1,…,N-1,0,…
- Grants and `req_ready` depend only on registered state. There is no combinational path from `out_ready` or `req_valid` to `req_ready`.
- In DONE, `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- Single stream: requester 0 sends 0x01, 0x02, 0x03, 0xFF (last), one per cycle, with `out_ready` = 1. Required: `out_sum` = 0x05, `out_id` = 0, and `out_valid` high exactly the cycle after the 0xFF transfer.
- Round-robin: after reset, all four requesters hold single-beat streams 0x10, 0x20, 0x30, 0x40. Required: results in order id 0,1,2,3 with sums 0x10, 0x20, 0x30, 0x40, then wrap to id 0 if requester 0 is re-asserted.
- Backpressure: in DONE with `out_sum` = 0x05, hold `out_ready` = 0 for 5 cycles. Required: `out_valid`, `out_sum` and `out_id` are held constant, `req_ready` = 0, and no new grant occurs. Release `out_ready`; the transfer happens and the next grant comes one cycle later.
- Bubbles: requester 2 sends 0x80, idle, idle, 0x80, idle, 0x01 (last). Required: `out_sum` = 0x01, `out_id` = 2, and `acc` is unchanged across the idle cycles.
- Stall of losers: requester 1 is granted while requester 3 holds `req_valid` high. Required: `req_ready[3]` = 0 throughout requester 1's stream; requester 3 is granted right after requester 1's result transfers.
- Reset mid-stream: assert `nrst` = 0 for one cycle after two beats of requester 0. Required: all outputs return to their reset values, no result is emitted, and a fresh stream 0x07 (last) then yields `out_sum` = 0x07.
